md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage; consumes operands and the decoded MD op from the ID/EX pipeline register.
- Holds the architectural HI/LO registers.
- Drives busy to the hazard/stall logic, which freezes PC, IF/ID and ID/EX while busy=1.
- HI/LO are read combinationally by MFHI/MFLO in EX.

---
 rtl/md_unit_pkg.sv | 35 +++
 rtl/md_div.sv | 71 +++++++
 rtl/md_unit.sv | 193 +++++++++++++++++++
 tb/tb_md_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared declarations for the multiply/divide unit: op encodings, FSM states, ID/EX op slice.
// MDU_MADD_EN widens the op field to 4 bits so MADD/MADDU/MSUB/MSUBU become reachable.
package md_unit_pkg;

`ifdef MDU_MADD_EN
  localparam int MD_OP_W = 4;
`else
  localparam int MD_OP_W = 3;
`endif

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  // 32 restoring iterations plus one sign-fix cycle; not tunable.
  localparam int DIV_CYCLES = 33;
  localparam int DIV_ITERS  = DIV_CYCLES - 1;

  localparam int IDEX_MD_OP_LSB = 8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_e;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} md_acc_e;

  function automatic logic [MD_OP_W-1:0] idex_md_op(input logic [31:0] idex_ctl);
    return idex_ctl[IDEX_MD_OP_LSB +: MD_OP_W];
  endfunction

endpackage

// File: rtl/md_div.sv
// Unsigned restoring divider core: one quotient bit per cycle, DIV_ITERS iterations.
// done is high during the cycle whose closing edge performs the final iteration.
module md_div
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] trial;

  assign done = run_q && (cnt_q == 6'(DIV_ITERS - 1));
  assign quo  = quo_q;
  assign rem  = rem_q;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    // Partial remainder shifted left by one with the next dividend bit, minus divisor.
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding HI/LO; busy stalls the front of the pipe.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into {hi,lo}.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic               cancel,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  md_state_e   state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
`ifdef MDU_MADD_EN
  md_acc_e     acc_q, acc_d;
`endif

  logic [3:0]  op_x;
  logic        sgn_div;
  logic [31:0] abs_a, abs_b;
  logic [63:0] ext_a, ext_b, prod;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;

  assign op_x    = 4'(op);
  assign sgn_div = (op_x == MD_DIV);
  assign abs_a   = (sgn_div && a[31]) ? (~a + 32'd1) : a;
  assign abs_b   = (sgn_div && b[31]) ? (~b + 32'd1) : b;

  // Low 64 bits of the product of extended operands are exact for both signednesses.
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  md_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (cancel),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div0_d    = div0_q;
    div_start = 1'b0;
`ifdef MDU_MADD_EN
    acc_d     = acc_q;
`endif
    unique case (state_q)
      S_IDLE: if (start && !cancel) begin
        unique case (op_x)
          MD_MTHI: hi_d = a;
          MD_MTLO: lo_d = a;
          MD_MULT, MD_MULTU: begin
            a_d     = a;
            b_d     = b;
            sgn_d   = (op_x == MD_MULT);
            cnt_d   = 4'(MUL_CYCLES - 1);
            state_d = S_MUL;
            busy_d  = 1'b1;
`ifdef MDU_MADD_EN
            acc_d   = ACC_NONE;
`endif
          end
`ifdef MDU_MADD_EN
          MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
            a_d     = a;
            b_d     = b;
            sgn_d   = (op_x == MD_MADD) || (op_x == MD_MSUB);
            acc_d   = (op_x == MD_MSUB || op_x == MD_MSUBU) ? ACC_SUB : ACC_ADD;
            cnt_d   = 4'(MUL_CYCLES - 1);
            state_d = S_MUL;
            busy_d  = 1'b1;
          end
`endif
          MD_DIV, MD_DIVU: begin
            negq_d    = sgn_div && (a[31] ^ b[31]);
            negr_d    = sgn_div && a[31];
            div0_d    = (b == 32'd0);
            div_start = 1'b1;
            state_d   = S_DIV;
            busy_d    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
`ifdef MDU_MADD_EN
          unique case (acc_q)
            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
            default: {hi_d, lo_d} = prod;
          endcase
`else
          {hi_d, lo_d} = prod;
`endif
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (div_done) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!cancel) begin
          // Divide by zero keeps the all-ones quotient regardless of dividend sign.
          lo_d = div0_q ? 32'hFFFF_FFFF : (negq_q ? (~div_quo + 32'd1) : div_quo);
          hi_d = negr_q ? (~div_rem + 32'd1) : div_rem;
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULC = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [MD_OP_W-1:0] op = '0;
  logic [31:0]        a = '0;
  logic [31:0]        b = '0;
  logic               cancel = 1'b0;
  logic               busy;
  logic [31:0]        hi, lo;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_unit #(.MUL_CYCLES(MULC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int lat_of(input logic [3:0] o);
    case (o)
      MD_MULT, MD_MULTU: return MULC;
      MD_DIV, MD_DIVU:   return 33;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return MULC;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      q, r;
    logic [63:0] p;
    case (o)
      MD_MTHI: exp_hi = x;
      MD_MTLO: exp_lo = x;
      MD_MULT: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        {exp_hi, exp_lo} = p;
      end
      MD_MULTU: {exp_hi, exp_lo} = {32'd0, x} * {32'd0, y};
      MD_DIV, MD_DIVU: begin
        if (y == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = x;
        end else if (o == MD_DIVU) begin
          exp_lo = x / y;
          exp_hi = x % y;
        end else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MSUB, MD_MADDU, MD_MSUBU: begin
        if (o == MD_MADD || o == MD_MSUB) p = 64'(longint'($signed(x)) * longint'($signed(y)));
        else p = {32'd0, x} * {32'd0, y};
        if (o == MD_MSUB || o == MD_MSUBU) {exp_hi, exp_lo} = {exp_hi, exp_lo} - p;
        else {exp_hi, exp_lo} = {exp_hi, exp_lo} + p;
      end
`endif
      default: ;
    endcase
  endfunction

  // Called just after a clock edge; returns just after the edge where busy has dropped.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int cancel_at, input int inj_at);
    int n, lat, want_n;
    bit killed;
    lat    = lat_of(o);
    killed = (cancel_at == 0) || (cancel_at > 0 && cancel_at < lat);
    want_n = (cancel_at == 0) ? 0 : (killed ? cancel_at + 1 : lat);
    op = MD_OP_W'(o); a = x; b = y; start = 1'b1; cancel = (cancel_at == 0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      if (n == cancel_at) cancel = 1'b1;
      if (n == inj_at) begin
        start = 1'b1; op = MD_OP_W'(MD_MULT); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; n++;
    end
    if (!killed) model(o, x, y);
    chk({tag, "_lat"}, 64'(n), 64'(want_n));
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [6];
    logic [3:0] o;
    int ca;
    ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV;
    ops[3] = MD_DIVU; ops[4] = MD_MTHI;  ops[5] = MD_MTLO;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, -1, -1);
    chk("mult_hi_abs", hi, 32'hFFFF_FFFF);
    do_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, -1);
    chk("multu_hi_abs", hi, 32'h0000_0001);
    do_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, -1, -1);
    chk("div_lo_abs", lo, 32'hFFFF_FFFD);
    do_op("divu0", MD_DIVU,  32'd7, 32'd0, -1, -1);
    do_op("div0s", MD_DIV,   32'hFFFF_FFF0, 32'd0, -1, -1);
    do_op("ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("ovf_lo_abs", lo, 32'h8000_0000);
    do_op("mthi",  MD_MTHI,  32'h1234_5678, 32'd0, -1, -1);
    do_op("mtlo",  MD_MTLO,  32'd9, 32'd0, -1, -1);
    do_op("inj",   MD_DIV,   32'd1000, 32'hFFFF_FFFD, -1, 5);
    do_op("cdiv",  MD_DIV,   32'd77, 32'd5, 10, -1);
    do_op("cmulE", MD_MULT,  32'd3, 32'd5, MULC - 1, -1);
    do_op("cidle", MD_MTHI,  32'hDEAD_BEEF, 32'd0, 0, -1);
    do_op("b2b",   MD_MULTU, 32'd6, 32'd7, -1, -1);

`ifdef MDU_MADD_EN
    do_op("pre_hi", MD_MTHI, 32'd0, 32'd0, -1, -1);
    do_op("pre_lo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, -1, -1);
    do_op("maddu", MD_MADDU, 32'd1, 32'd1, -1, -1);
    chk("maddu_hi_abs", hi, 32'd1);
    do_op("msub",  MD_MSUB,  32'hFFFF_FFFE, 32'd3, -1, -1);
`else
    do_op("maddu_off", MD_MADDU, 32'd1, 32'd1, -1, -1);
`endif

    for (int i = 0; i < 40; i++) begin
      o  = ops[$urandom_range(0, 5)];
      ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 33)) : -1;
      do_op("rnd", o, rnd_opnd(), rnd_opnd(), ca, -1);
    end

    // Asynchronous reset 20 cycles into a divide.
    op = MD_OP_W'(MD_DIV); a = 32'd12345; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("post_rst", MD_MULT, 32'hFFFF_FFFD, 32'h7FFF_FFFF, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
